// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART message sequencer and its frame serializer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Serial bit slots in one frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Single-frame UART serializer: baud counter plus bit shifter, loaded through a
// load/ready handshake that allows back-to-back frames with no idle gap.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 frame_end,
    output logic                 tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity;
    logic                 bit_end;
    logic                 accept;
    logic                 shift_en;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = (state == ST_STOP) && bit_end && (stop_cnt == STOP_LAST);
    // Ready during the final stop cycle so the next frame starts with no gap.
    assign ready     = (state == ST_IDLE) || frame_end;
    assign accept    = load && ready;
    assign shift_en  = (state == ST_DATA) && bit_end && (bit_cnt != BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
        end else if (clear) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
        end else if (accept) begin
            state    <= ST_START;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt + CW'(1);
            end else begin
                baud_cnt <= '0;
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= ST_PARITY;
                                tx    <= parity;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            tx      <= shreg[1];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                    end
                    ST_STOP: begin
                        if (stop_cnt == STOP_LAST) begin
                            state    <= ST_IDLE;
                            stop_cnt <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                        tx <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Byte payload is held without reset; the state machine decides whether it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg  <= data;
            parity <= (^data) ^ (PARITY_ODD != 0);
        end else if (shift_en) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Sends a stored message out of a small RAM as back-to-back UART frames,
// launched by a rising edge on start, with optional looping and abort.
module uart_msg_sequencer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [AW:0]          msg_len,
    input  logic                 start,
    input  logic                 repeat_en,
    input  logic                 abort,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        byte_idx
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    logic [DATA_BITS-1:0] ram [DEPTH];
    logic                 start_q;
    logic [AW:0]          len_q;
    logic [AW:0]          eff_len;
    logic                 start_edge;
    logic                 launch;
    logic                 clear;
    logic                 byte_last;
    logic                 pass_end;
    logic                 relaunch;
    logic                 next_byte;
    logic                 load;
    logic                 ready;
    logic                 frame_end;
    logic [AW-1:0]        load_addr;

    function automatic logic [AW:0] clip_len(input logic [AW:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    assign eff_len    = clip_len(msg_len);
    assign start_edge = start && !start_q;
    assign launch     = !busy && ready && start_edge && (eff_len != '0);
    assign clear      = abort && busy;
    assign byte_last  = ({1'b0, byte_idx} == (len_q - (AW+1)'(1)));
    // Abort on the final stop cycle wins: no done, no next byte.
    assign pass_end   = busy && frame_end && !abort && byte_last;
    assign next_byte  = busy && frame_end && !abort && !byte_last;
    assign relaunch   = pass_end && repeat_en && (eff_len != '0);
    assign load       = launch || relaunch || next_byte;
    assign load_addr  = next_byte ? (byte_idx + AW'(1)) : '0;

    // Read-before-write: a write landing on the latch edge leaves the old byte in the frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= '0;
            len_q    <= '0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            if (clear) begin
                busy     <= 1'b0;
                byte_idx <= '0;
            end else if (launch) begin
                busy     <= 1'b1;
                byte_idx <= '0;
                len_q    <= eff_len;
            end else if (next_byte) begin
                byte_idx <= load_addr;
            end else if (pass_end) begin
                done     <= 1'b1;
                byte_idx <= '0;
                if (relaunch) begin
                    len_q <= eff_len;
                end else begin
                    busy <= 1'b0;
                end
            end
        end
    end

    uart_tx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY_EN    (PARITY_EN),
        .PARITY_ODD   (PARITY_ODD),
        .STOP_BITS    (STOP_BITS)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .load      (load),
        .data      (ram[load_addr]),
        .ready     (ready),
        .frame_end (frame_end),
        .tx        (tx)
    );

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Bench for uart_msg_sequencer: expected serial waveform built per cycle from
// the byte values and frame rules, compared against tx/busy/done/byte_idx.
module tb_uart_msg_sequencer;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int FL0   = 10;  // start + 8 data + 1 stop
    localparam int FL1   = 12;  // start + 8 data + parity + 2 stop

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] msg_len;
    logic       start, start1, repeat_en, abort;
    logic       tx, busy, done;
    logic [3:0] byte_idx;
    logic       tx1, busy1, done1;
    logic [3:0] byte_idx1;

    logic [7:0] shadow [DEPTH];
    logic [7:0] pass_bytes [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_msg_sequencer #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .DEPTH(DEPTH),
        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .start(start), .repeat_en(repeat_en), .abort(abort),
        .tx(tx), .busy(busy), .done(done), .byte_idx(byte_idx)
    );

    uart_msg_sequencer #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .DEPTH(DEPTH),
        .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_par (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .start(start1), .repeat_en(1'b0), .abort(abort),
        .tx(tx1), .busy(busy1), .done(done1), .byte_idx(byte_idx1)
    );

    typedef struct {
        logic [4:0] msg_len;
        int         exp_bytes;
        bit         fixed_data;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Line level of bit slot k of a frame carrying byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int k, input bit par_en, input bit odd);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (par_en && k == 9) return (^d) ^ odd;
        return 1'b1;
    endfunction

    task automatic write_ram(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        shadow[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic launch();
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
    endtask

    // Checks one full pass of nb bytes starting with the first start-bit cycle.
    task automatic run_pass(input int nb, input logic dn0, input int abort_at, input int wr_at,
                            input logic [7:0] wr_val, input int rep_clear_at, input int tog_at);
        int slot;
        int b;
        for (int j = 0; j < DEPTH; j++) pass_bytes[j] = shadow[j];
        for (int i = 0; i < nb * FL0 * CPB; i++) begin
            @(negedge clk);
            b    = i / (FL0 * CPB);
            slot = (i % (FL0 * CPB)) / CPB;
            chk("tx", 32'(tx), 32'(exp_bit(pass_bytes[b], slot, 1'b0, 1'b0)));
            chk("busy", 32'(busy), 32'd1);
            chk("byte_idx", 32'(byte_idx), 32'(b));
            chk("done", 32'(done), (i == 0) ? 32'(dn0) : 32'd0);
            wr_en = 1'b0;
            if (i == wr_at) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = wr_val;
                shadow[1] = wr_val;
            end
            if (i == rep_clear_at) repeat_en = 1'b0;
            if (i == tog_at) start = 1'b0;
            if (i == tog_at + 2) start = 1'b1;
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_tx", 32'(tx), 32'd1);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_byte_idx", 32'(byte_idx), 32'd0);
                return;
            end
        end
    endtask

    task automatic check_end();
        @(negedge clk);
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_tx", 32'(tx), 32'd1);
        chk("end_byte_idx", 32'(byte_idx), 32'd0);
        @(negedge clk);
        chk("end_done_pulse", 32'(done), 32'd0);
        chk("end_busy_low", 32'(busy), 32'd0);
    endtask

    task automatic expect_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(name, {29'd0, busy, done, tx}, 32'b001);
        end
    endtask

    initial begin
        int nexp;
        int ml;
        reset = 1'b1; start = 1'b0; start1 = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; repeat_en = 1'b0; abort = 1'b0;
        vecs[0] = '{5'd4,  4,  1'b1};
        vecs[1] = '{5'd0,  0,  1'b0};
        vecs[2] = '{5'd20, 16, 1'b0};
        vecs[3] = '{5'd1,  1,  1'b0};
        vecs[4] = '{5'd16, 16, 1'b0};
        vecs[5] = '{5'd3,  3,  1'b0};

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_byte_idx", 32'(byte_idx), 32'd0);
        chk("rst_tx_par", 32'(tx1), 32'd1);
        reset = 1'b0;

        // Table-driven messages; row 0 also toggles start mid-pass (must be ignored).
        for (int r = 0; r < 6; r++) begin
            if (vecs[r].fixed_data) begin
                write_ram(0, 8'hFF); write_ram(1, 8'hBB); write_ram(2, 8'hCC); write_ram(3, 8'hB2);
            end else begin
                for (int a = 0; a < DEPTH; a++) write_ram(a, 8'($urandom));
            end
            msg_len = vecs[r].msg_len;
            launch();
            if (vecs[r].exp_bytes == 0) begin
                expect_idle(20, "len0_idle");
            end else begin
                run_pass(vecs[r].exp_bytes, 1'b0, -1, -1, 8'h00, -1, (r == 0) ? 100 : -1);
                check_end();
                expect_idle(3, "post_idle");
            end
        end

        // Randomized lengths and contents.
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < DEPTH; a++) write_ram(a, 8'($urandom));
            ml = $urandom_range(1, 20);
            nexp = (ml > DEPTH) ? DEPTH : ml;
            msg_len = 5'(ml);
            launch();
            run_pass(nexp, 1'b0, -1, -1, 8'h00, -1, -1);
            check_end();
        end

        // Repeat mode with writes to RAM[1] on its latch edge and mid-byte.
        write_ram(0, 8'h3C); write_ram(1, 8'h81);
        msg_len = 5'd2;
        repeat_en = 1'b1;
        launch();
        run_pass(2, 1'b0, -1, 39, 8'h5A, -1, -1);
        run_pass(2, 1'b1, -1, 45, 8'hE7, -1, -1);
        run_pass(2, 1'b1, -1, -1, 8'h00, 20, -1);
        check_end();

        // Abort on the third data bit of byte 1, then relaunch.
        for (int a = 0; a < 4; a++) write_ram(a, 8'($urandom));
        msg_len = 5'd4;
        launch();
        run_pass(4, 1'b0, 52, -1, 8'h00, -1, -1);
        expect_idle(50, "abort_idle");
        launch();
        run_pass(4, 1'b0, -1, -1, 8'h00, -1, -1);
        check_end();

        // Abort on the final stop cycle suppresses done.
        msg_len = 5'd1;
        launch();
        run_pass(1, 1'b0, FL0 * CPB - 1, -1, 8'h00, -1, -1);
        expect_idle(5, "abort_last_idle");

        // Asynchronous reset mid data bit, start held high across release.
        msg_len = 5'd4;
        launch();
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_byte_idx", 32'(byte_idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_pass(4, 1'b0, -1, -1, 8'h00, -1, -1);
        check_end();
        expect_idle(30, "held_start_idle");
        start = 1'b0;

        // Parity instance: odd parity, two stop bits, byte A5.
        write_ram(0, 8'hA5);
        msg_len = 5'd1;
        start1 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        for (int i = 0; i < FL1 * CPB; i++) begin
            @(negedge clk);
            chk("par_tx", 32'(tx1), 32'(exp_bit(8'hA5, i / CPB, 1'b1, 1'b1)));
            chk("par_busy", 32'(busy1), 32'd1);
            chk("par_done", 32'(done1), 32'd0);
            if (i == 9 * CPB) chk("par_bit", 32'(tx1), 32'd1);
        end
        @(negedge clk);
        chk("par_end_done", 32'(done1), 32'd1);
        chk("par_end_busy", 32'(busy1), 32'd0);
        chk("par_end_tx", 32'(tx1), 32'd1);
        start1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
